instr_issuer: RTL
=================

Name: instr_issuer

Overview:
Instruction-issuing front end for the simple processor datapath: the initiator side of the processor's func/input1/input2 command interface.
- A host writes instruction words into a small FIFO.
- The issuer pops one word at a time, drives func/in1/in2, and pulses run.
- It holds the operands stable until the control FSM returns done, then retires the instruction and issues the next.

Parameters:
DATA_W, 8, width of the immediate data word driven toward the bus (in2)
DEPTH, 4, instruction FIFO depth in entries (power of 2, >=2)
TIMEOUT, 16, maximum cycles spent in WAIT before watchdog abort (used only with the optional feature)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  permits popping new instructions; an in-flight instruction always completes
wr_en  input  1  host write strobe
wr_func  input  3  opcode (load, move, add, sub, xor)
wr_rx  input  3  destination/first register select
wr_data  input  DATA_W  immediate data, or source register index in low 3 bits
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
ovf  output  1  sticky: a write was dropped while full
func  output  3  opcode presented to the processor
in1  output  3  register select presented to the processor
in2  output  DATA_W  data presented to the processor
run  output  1  one-cycle start pulse
done  input  1  processor completion strobe
busy  output  1  state != IDLE
retired  output  8  count of completed instructions, wraps 255->0
err  output  1  sticky watchdog error (0 when feature absent)

Behaviour:
- Reset value of every output and register is 0, except empty=1. On reset:
  - FIFO pointers and count clear.
  - FSM goes to IDLE.
  - ovf, err and retired clear.
  - Reset mid-WAIT abandons the instruction; no retire is counted.
- FIFO is registered; count ranges 0..DEPTH; pointers wrap modulo DEPTH.
  - Write is accepted iff wr_en && !full, using the registered full.
  - Write while full is dropped and sets ovf, even if a pop occurs the same cycle.
  - Simultaneous accepted write and pop: count is unchanged.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If enable && !empty: pop the head into the func/in1/in2 output registers and go to ISSUE.
  - Otherwise stay; func/in1/in2 hold their last values.
- ISSUE: run=1 for exactly this cycle; go to WAIT.
- WAIT:
  - run=0; func/in1/in2 stay stable.
  - On done=1: retired increments and the FSM goes to IDLE.
- done is ignored in IDLE and ISSUE.
- Latency and throughput:
  - Word written at edge N into an empty FIFO: empty falls after edge N.
  - Popped at edge N+1; run high in cycle N+1..N+2.
  - Back-to-back minimum is 3 cycles per instruction (ISSUE, WAIT with done, IDLE pop).
- enable deasserted during ISSUE/WAIT: the current instruction completes normally, then the FSM idles with the FIFO intact.

Optional Feature:
INSTR_ISSUER_WATCHDOG_EN
- With the macro:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle without done.
  - When it reaches TIMEOUT, err sets (sticky) and the FSM returns to IDLE without incrementing retired.
  - done in the same cycle as the timeout wins: the instruction retires normally.
- Without the macro: no counter exists, err is tied to 0, and WAIT is held indefinitely.

Test Plan:
- Reset: assert reset mid-WAIT with 2 entries queued -> run=0, busy=0, empty=1, retired=0, func/in1/in2=0, immediately (asynchronous).
- Single issue: write func=1, rx=3, data=0x5A; done returned 2 cycles after run -> run high exactly 1 cycle; func=1/in1=3/in2=0x5A held until done; retired=1.
- Full/overflow: enable=0, write 5 entries with DEPTH=4 -> full=1 after the 4th, 5th dropped, ovf=1; enable=1 and return done each time -> exactly 4 issues in FIFO order.
- Back-to-back: 3 queued, done returned on the first WAIT cycle -> run pulses spaced exactly 3 cycles apart; retired=3.
- Enable gating: deassert enable during WAIT of instruction 1 with 2 queued -> instruction 1 retires, no further run; re-enable -> next run starts 1 cycle later.
- Watchdog (INSTR_ISSUER_WATCHDOG_EN, TIMEOUT=16): done never returned -> FSM returns to IDLE after 16 WAIT cycles, err=1, retired unchanged; next instruction issues.

Source files
------------

// File: rtl/instr_issuer_if.sv
// Processor command bus: func/in1/in2 operands, run start pulse, done strobe.
// The issuer drives the master side; the processor control FSM is the slave.
interface instr_issuer_if #(
    parameter int DATA_W = 8
);
    logic [2:0]        func;
    logic [2:0]        in1;
    logic [DATA_W-1:0] in2;
    logic              run;
    logic              done;

    modport master (
        output func, in1, in2, run,
        input  done
    );

    modport slave (
        input  func, in1, in2, run,
        output done
    );
endinterface

// File: rtl/instr_issuer.sv
// Instruction FIFO plus IDLE/ISSUE/WAIT issue FSM for the processor command bus.
// Optional watchdog on WAIT enabled by defining INSTR_ISSUER_WATCHDOG_EN.
module instr_issuer #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [2:0]        wr_func,
    input  logic [2:0]        wr_rx,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    instr_issuer_if.master    bus,
    output logic              busy,
    output logic [7:0]        retired,
    output logic              err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [2:0]        func;
        logic [2:0]        rx;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    logic          push;
    logic          pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && enable && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{func: wr_func, rx: wr_rx, data: wr_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef INSTR_ISSUER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wdog;
`else
    logic unused_cfg;
    assign unused_cfg = TIMEOUT[0];
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bus.func <= '0;
            bus.in1  <= '0;
            bus.in2  <= '0;
            bus.run  <= 1'b0;
            retired  <= '0;
`ifdef INSTR_ISSUER_WATCHDOG_EN
            wdog     <= '0;
            err      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bus.run <= 1'b0;
                    if (pop) begin
                        bus.func <= mem[rd_ptr].func;
                        bus.in1  <= mem[rd_ptr].rx;
                        bus.in2  <= mem[rd_ptr].data;
                        bus.run  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.run <= 1'b0;
                    state   <= WAIT;
`ifdef INSTR_ISSUER_WATCHDOG_EN
                    wdog    <= '0;
`endif
                end
                WAIT: begin
                    // done beats a simultaneous timeout.
                    if (bus.done) begin
                        retired <= retired + 8'd1;
                        state   <= IDLE;
`ifdef INSTR_ISSUER_WATCHDOG_EN
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
